// File: rtl/exu_div_if.sv
// Request/response bundle between the execute stage and the iterative divider.
interface exu_div_if #(
  parameter int unsigned XLEN = 32
);
  // Request side, sourced from the ID/EX register and execute control
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic [4:0]      rd_waddr;
  logic            flush;

  // Response side, sourced by the divider
  logic            hold_req;
  logic            busy;
  logic            valid;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_waddr_o;

  modport master (
    output start, op, dividend, divisor, rd_waddr, flush,
    input  hold_req, busy, valid, result, rd_waddr_o
  );

  modport slave (
    input  start, op, dividend, divisor, rd_waddr, flush,
    output hold_req, busy, valid, result, rd_waddr_o
  );
endinterface

// File: rtl/exu_div.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// Special cases (divide by zero, signed overflow) bypass the iteration.
module exu_div #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic     clk,
  input  logic     rst,
  exu_div_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  ALL_ONES  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quot_q, quot_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic             is_rem_q, is_rem_d;
  logic [4:0]       rd_q, rd_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic             sgn, a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic [XLEN:0]    rem_sh, diff;
  logic [XLEN-1:0]  quot_sh, rem_nx, quot_nx;
  logic             hold_req_c;

  // Operand magnitudes, sign flags and special-case detection on the request
  always_comb begin
    sgn      = ~bus.op[0];
    a_neg    = sgn & bus.dividend[XLEN-1];
    b_neg    = sgn & bus.divisor[XLEN-1];
    a_mag    = a_neg ? (XLEN'(0) - bus.dividend) : bus.dividend;
    b_mag    = b_neg ? (XLEN'(0) - bus.divisor)  : bus.divisor;
    div_zero = (bus.divisor == '0);
    ovf      = sgn & (bus.dividend == INT_MIN) & (bus.divisor == ALL_ONES);
  end

  // One restoring step: shift {rem,quot} left, trial-subtract the divisor.
  // The partial remainder is kept one bit wider so a large divisor cannot lose the MSB.
  always_comb begin
    rem_sh  = {rem_q, quot_q[XLEN-1]};
    quot_sh = {quot_q[XLEN-2:0], 1'b0};
    diff    = rem_sh - {1'b0, dvs_q};
    if (!diff[XLEN]) begin
      rem_nx  = diff[XLEN-1:0];
      quot_nx = quot_sh | XLEN'(1);
    end else begin
      rem_nx  = rem_sh[XLEN-1:0];
      quot_nx = quot_sh;
    end
  end

  // Next-state, datapath update and stall request
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvs_d      = dvs_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    is_rem_d   = is_rem_q;
    rd_d       = rd_q;
    result_d   = result_q;
    hold_req_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          hold_req_c = 1'b1;
          is_rem_d   = bus.op[1];
          neg_quot_d = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          rd_d       = bus.rd_waddr;
          cnt_d      = '0;
          if (div_zero) begin
            result_d = bus.op[1] ? bus.dividend : ALL_ONES;
            state_d  = S_DONE;
          end else if (ovf) begin
            result_d = bus.op[1] ? '0 : INT_MIN;
            state_d  = S_DONE;
          end else begin
            rem_d   = '0;
            quot_d  = a_mag;
            dvs_d   = b_mag;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        hold_req_c = 1'b1;
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d  = rem_nx;
          quot_d = quot_nx;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            state_d = S_DONE;
            if (is_rem_q) begin
              result_d = neg_rem_q ? (XLEN'(0) - rem_nx) : rem_nx;
            end else begin
              result_d = neg_quot_q ? (XLEN'(0) - quot_nx) : quot_nx;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvs_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      is_rem_q   <= 1'b0;
      rd_q       <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvs_q      <= dvs_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      is_rem_q   <= is_rem_d;
      rd_q       <= rd_d;
      result_q   <= result_d;
    end
  end

  // Status decoded straight from the state register
  assign bus.hold_req   = hold_req_c;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.valid      = (state_q == S_DONE);
  assign bus.result     = result_q;
  assign bus.rd_waddr_o = rd_q;

endmodule

// File: doc/exu_div.md
Name: exu_div

Overview:
- Iterative 32-bit integer divide unit for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the execute stage, directly downstream of the ID/EX pipeline register. It consumes that register's rs1/rs2 read data, rd write address and funct3.
- Raises a hold request that freezes the upstream pipeline registers until the quotient or remainder is ready for writeback.

Parameters:
- XLEN, 32, operand and result width
- CNT_W, 6, width of the iteration counter (must hold XLEN)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  divide request from execute decode; sampled only in IDLE
- op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend  input  XLEN  rs1 data from the ID/EX register
- divisor  input  XLEN  rs2 data from the ID/EX register
- rd_waddr  input  5  destination register of the request
- flush  input  1  branch/trap kill; aborts any operation in flight
- hold_req  output  1  stall request to all upstream pipeline registers
- busy  output  1  unit not in IDLE
- valid  output  1  result valid, single-cycle pulse
- result  output  XLEN  quotient or remainder per the latched op
- rd_waddr_o  output  5  latched destination register, aligned with valid

Behaviour:
- Reset: rst low asynchronously forces state IDLE. Reset values: counter 0, result 0, rd_waddr_o 0, valid 0, busy 0, hold_req 0. A reset mid-operation discards the operation.
- States and transitions:
  - IDLE: start=1 and flush=0 latches op, rd_waddr, operand magnitudes and sign flags. Next state is CALC, or DONE if a special case applies.
  - CALC: one restoring-division step per cycle. Shift the {rem,quot} pair left by 1 and trial-subtract the divisor magnitude. If the difference is non-negative, keep it and set the quotient LSB. After XLEN steps, go to DONE.
  - DONE: valid=1, result and rd_waddr_o stable. Next state is IDLE.
- Latency: start high in cycle 0. CALC occupies cycles 1..32. valid is high in cycle 33. Special cases give valid in cycle 1.
- hold_req = (IDLE & start & ~flush) | CALC. It is combinational on start, so the ID/EX register freezes in cycle 0. hold_req is low in the DONE cycle so the pipeline advances and captures the result.
- busy = state != IDLE.
- Signed ops (DIV, REM):
  - Operate on absolute values.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Unsigned ops use the raw operands.
- Special cases, per RISC-V spec, resolved on the fast path:
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
  - DIV overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000; REM gives 0.
- start while busy is ignored; it never restarts the operation.
- flush in any state: next edge goes to IDLE with valid 0. Flush in DONE suppresses nothing, because valid is already driven that cycle. flush and start together in IDLE: start is ignored.
- result holds its last value outside DONE. Consumers qualify it with valid.

Test Plan:
- DIVU 100/7, start in cycle 0 -> hold_req high cycles 0..32; valid only in cycle 33 with result=14 and rd_waddr_o=the latched rd.
- DIV 0xFFFFFFF9/2 -> result 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. REMU with the same operands -> 0x00000001.
- Divisor 0: DIV 5/0 -> 0xFFFFFFFF at cycle 1. REMU 5/0 -> 5 at cycle 1. hold_req high only in cycle 0.
- Overflow DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at cycle 1. REM with the same operands -> 0.
- DIVU 100/7 with flush in cycle 10 -> IDLE in cycle 11; no valid pulse. A new start in cycle 12 completes normally with valid in cycle 45.
- rst pulsed low in cycle 15 of an operation -> immediately busy=0, hold_req=0, result=0. A second start while busy (cycle 5) -> ignored; the original result is delivered in cycle 33.
